enemy_swarm: RTL and testbench

ENEMY_SWARM -- requirements
Module: enemy_swarm

---
 rtl/enemy_swarm.sv | 162 ++++++++++++++++
 tb/tb_enemy_swarm.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/enemy_swarm.sv
// Enemy swarm: N independent lanes that wander on an LFSR-driven random walk, die when hit and
// (when ENEMY_RESPAWN_EN is defined) respawn at START_POS after a fixed number of ticks.
module enemy_swarm #(
  parameter int          N_ENEMY       = 2,
  parameter int          POS_W         = 3,
  parameter int          POS_MIN       = 1,
  parameter int          POS_MAX       = 6,
  parameter int          START_POS     = 3,
  parameter int          TICK_DIV      = 1000,
  parameter int          DIE_TICKS     = 4,
  parameter int          RESPAWN_TICKS = 8,
  parameter logic [15:0] SEED          = 16'hACE1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [N_ENEMY-1:0]         hit,
  output logic [N_ENEMY*POS_W-1:0]   enemy_pos,
  output logic [N_ENEMY-1:0]         alive,
  output logic [N_ENEMY-1:0]         visible,
  output logic                       tick,
  output logic [7:0]                 kill_cnt
);

  localparam int DIV_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int TMAX  = (DIE_TICKS > RESPAWN_TICKS) ? DIE_TICKS : RESPAWN_TICKS;
  localparam int TC_W  = $clog2(TMAX + 1);

  typedef enum logic [1:0] {S_ALIVE, S_DYING, S_DEAD} lane_st_e;

  logic [DIV_W-1:0] div_q, div_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [7:0]       kill_q, kill_d;
  lane_st_e         st_q  [N_ENEMY];
  lane_st_e         st_d  [N_ENEMY];
  logic [POS_W-1:0] pos_q [N_ENEMY];
  logic [POS_W-1:0] pos_d [N_ENEMY];
  logic [TC_W-1:0]  tc_q  [N_ENEMY];
  logic [TC_W-1:0]  tc_d  [N_ENEMY];
  logic [N_ENEMY-1:0] vis_q, vis_d;
  logic [N_ENEMY-1:0] acc;
  logic [4:0]         pop;
  logic               tick_w;

  function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [4:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {4'b0000, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  // Divider and LFSR; the divider only advances while enabled, so tick can't fire when en=0.
  assign tick_w = en && (div_q == DIV_W'(TICK_DIV - 1));

  always_comb begin
    div_d = div_q;
    if (en) div_d = tick_w ? '0 : div_q + DIV_W'(1);
    lfsr_d = lfsr_q;
    if (tick_w) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  // Lane FSMs; a hit in ALIVE pre-empts movement on the same clk.
  always_comb begin
    acc   = '0;
    vis_d = vis_q;
    for (int i = 0; i < N_ENEMY; i++) begin
      st_d[i]  = st_q[i];
      pos_d[i] = pos_q[i];
      tc_d[i]  = tc_q[i];
      case (st_q[i])
        S_ALIVE: begin
          if (hit[i]) begin
            acc[i]   = 1'b1;
            st_d[i]  = S_DYING;
            tc_d[i]  = '0;
            vis_d[i] = 1'b1;
          end else if (tick_w) begin
            if (!lfsr_q[i])
              pos_d[i] = (pos_q[i] < POS_W'(POS_MAX)) ? pos_q[i] + POS_W'(1) : pos_q[i] - POS_W'(1);
            else
              pos_d[i] = (pos_q[i] > POS_W'(POS_MIN)) ? pos_q[i] - POS_W'(1) : pos_q[i] + POS_W'(1);
          end
        end
        S_DYING: begin
          if (tick_w) begin
            if (tc_q[i] == TC_W'(DIE_TICKS - 1)) begin
              st_d[i]  = S_DEAD;
              tc_d[i]  = '0;
              vis_d[i] = 1'b0;
            end else begin
              tc_d[i]  = tc_q[i] + TC_W'(1);
              vis_d[i] = ~vis_q[i];
            end
          end
        end
        S_DEAD: begin
`ifdef ENEMY_RESPAWN_EN
          if (tick_w) begin
            if (tc_q[i] == TC_W'(RESPAWN_TICKS - 1)) begin
              st_d[i]  = S_ALIVE;
              pos_d[i] = POS_W'(START_POS);
              tc_d[i]  = '0;
              vis_d[i] = 1'b1;
            end else begin
              tc_d[i] = tc_q[i] + TC_W'(1);
            end
          end
`else
          vis_d[i] = 1'b0;
`endif
        end
        default: begin
          st_d[i]  = S_ALIVE;
          pos_d[i] = POS_W'(START_POS);
          tc_d[i]  = '0;
          vis_d[i] = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_ENEMY; i++) pop = pop + 5'(acc[i]);
    kill_d = sat_add8(kill_q, pop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      div_q  <= '0;
      lfsr_q <= SEED;
      kill_q <= '0;
      vis_q  <= '1;
      for (int i = 0; i < N_ENEMY; i++) begin
        st_q[i]  <= S_ALIVE;
        pos_q[i] <= POS_W'(START_POS);
        tc_q[i]  <= '0;
      end
    end else begin
      div_q  <= div_d;
      lfsr_q <= lfsr_d;
      kill_q <= kill_d;
      vis_q  <= vis_d;
      for (int i = 0; i < N_ENEMY; i++) begin
        st_q[i]  <= st_d[i];
        pos_q[i] <= pos_d[i];
        tc_q[i]  <= tc_d[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_ENEMY; i++) begin
      enemy_pos[i*POS_W +: POS_W] = pos_q[i];
      alive[i]                    = (st_q[i] == S_ALIVE);
    end
  end

  assign visible  = vis_q;
  assign tick     = tick_w;
  assign kill_cnt = kill_q;

endmodule

// File: tb/tb_enemy_swarm.sv
// Bench for enemy_swarm: per-cycle reference model plus directed scenarios with literal expectations.
module tb_enemy_swarm;
  localparam int          TD    = 4;
  localparam int          PMIN  = 1;
  localparam int          PMAX  = 6;
  localparam int          START = 3;
  localparam int          DIE   = 4;
  localparam int          RESP  = 8;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en  = 1'b0;
  logic [1:0] hit = 2'b00;
  logic [5:0] enemy_pos;
  logic [1:0] alive, visible;
  logic       tick;
  logic [7:0] kill_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  enemy_swarm #(
    .N_ENEMY(2), .POS_W(3), .POS_MIN(PMIN), .POS_MAX(PMAX), .START_POS(START),
    .TICK_DIV(TD), .DIE_TICKS(DIE), .RESPAWN_TICKS(RESP), .SEED(SEED)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .hit(hit), .enemy_pos(enemy_pos),
    .alive(alive), .visible(visible), .tick(tick), .kill_cnt(kill_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model: lane state 0=alive 1=dying 2=dead, ticks counted since entering the state.
  int          m_st [2];
  int          m_pos[2];
  int          m_tc [2];
  int          m_kill, m_div, m_n;
  logic [15:0] m_lfsr;
  bit          m_valid = 0;
  bit          m_tk;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid = 1;
      m_div   = 0;
      m_kill  = 0;
      m_lfsr  = SEED;
      for (int i = 0; i < 2; i++) begin
        m_st[i] = 0; m_pos[i] = START; m_tc[i] = 0;
      end
    end else if (m_valid) begin
      m_tk = en && (m_div == TD - 1);
      m_n  = 0;
      for (int i = 0; i < 2; i++) begin
        if (m_st[i] == 0) begin
          if (hit[i]) begin
            m_st[i] = 1; m_tc[i] = 0; m_n++;
          end else if (m_tk) begin
            if (m_lfsr[i] == 1'b0) m_pos[i] = (m_pos[i] == PMAX) ? PMAX - 1 : m_pos[i] + 1;
            else                   m_pos[i] = (m_pos[i] == PMIN) ? PMIN + 1 : m_pos[i] - 1;
          end
        end else if (m_st[i] == 1) begin
          if (m_tk) begin
            m_tc[i]++;
            if (m_tc[i] == DIE) begin m_st[i] = 2; m_tc[i] = 0; end
          end
        end else begin
          if (m_tk) begin
            m_tc[i]++;
`ifdef ENEMY_RESPAWN_EN
            if (m_tc[i] == RESP) begin m_st[i] = 0; m_pos[i] = START; m_tc[i] = 0; end
`endif
          end
        end
      end
      m_kill = (m_kill + m_n > 255) ? 255 : m_kill + m_n;
      if (m_tk) m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
      if (en) m_div = (m_div + 1) % TD;
    end
  end

  function automatic logic m_vis(input int st, input int tc);
    if (st == 0) return 1'b1;
    if (st == 1) return (tc % 2 == 0);
    return 1'b0;
  endfunction

  logic [18:0] exp_vec, act_vec;
  always @(negedge clk) begin
    if (m_valid) begin
      exp_vec = {3'(m_pos[1]), 3'(m_pos[0]),
                 1'(m_st[1] == 0), 1'(m_st[0] == 0),
                 m_vis(m_st[1], m_tc[1]), m_vis(m_st[0], m_tc[0]),
                 1'(en && (m_div == TD - 1)), 8'(m_kill)};
      act_vec = {enemy_pos, alive, visible, tick, kill_cnt};
      check("model_cycle", 32'(act_vec), 32'(exp_vec));
      check("pos_range", 32'((enemy_pos[2:0] >= 3'(PMIN)) && (enemy_pos[2:0] <= 3'(PMAX)) &&
                             (enemy_pos[5:3] >= 3'(PMIN)) && (enemy_pos[5:3] <= 3'(PMAX))), 32'd1);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; step(); rst = 1'b1;
  endtask

  // Step until a tick is visible, then step across the edge that consumes it.
  task automatic next_tick();
    int b = 0;
    while (tick !== 1'b1 && b < 20) begin step(); b++; end
    if (b >= 20) check("tick_timeout", 32'd0, 32'd1);
    step();
  endtask

  int vis_exp[4] = '{0, 1, 0, 0};

  initial begin
    rst = 1'b0; en = 1'b0; hit = 2'b00;
    repeat (3) step();
    check("rst_pos",     32'(enemy_pos), 32'(6'b011_011));
    check("rst_alive",   32'(alive),     32'd3);
    check("rst_visible", 32'(visible),   32'd3);
    check("rst_tick",    32'(tick),      32'd0);
    check("rst_kill",    32'(kill_cnt),  32'd0);

    // First tick after release, first two moves from SEED=ACE1 then 59C3.
    en = 1'b1; rst = 1'b1;
    step(); check("tick_e1", 32'(tick), 32'd0);
    step(); check("tick_e2", 32'(tick), 32'd0);
    step(); check("tick_e3", 32'(tick), 32'd1);
    step(); check("first_move", 32'(enemy_pos), 32'(6'b100_010));
    check("tick_e4", 32'(tick), 32'd0);
    repeat (4) step();
    check("second_move", 32'(enemy_pos), 32'(6'b011_001));

    // Hit on lane 0 coincident with the first tick.
    do_reset();
    step(); step(); step();
    check("tick_before_hit", 32'(tick), 32'd1);
    hit = 2'b01; step(); hit = 2'b00;
    check("hit_tick_pos",   32'(enemy_pos), 32'(6'b100_011));
    check("hit_tick_alive", 32'(alive),     32'd2);
    check("hit_tick_kill",  32'(kill_cnt),  32'd1);

    // Double hit, ignored re-hits while dying, visible blink pattern.
    do_reset();
    hit = 2'b11; step(); hit = 2'b01;
    check("dbl_kill",    32'(kill_cnt), 32'd2);
    check("dbl_alive",   32'(alive),    32'd0);
    check("dbl_visible", 32'(visible),  32'd3);
    for (int k = 0; k < 4; k++) begin
      next_tick();
      check("die_visible", 32'(visible[0]), 32'(vis_exp[k]));
    end
    hit = 2'b00;
    check("dying_kill_hold", 32'(kill_cnt), 32'd2);
    check("dead_alive",      32'(alive),    32'd0);
`ifdef ENEMY_RESPAWN_EN
    for (int k = 0; k < 7; k++) next_tick();
    check("pre_respawn_alive", 32'(alive), 32'd0);
    next_tick();
    check("respawn_alive",   32'(alive),     32'd3);
    check("respawn_pos",     32'(enemy_pos), 32'(6'b011_011));
    check("respawn_visible", 32'(visible),   32'd3);
`else
    for (int k = 0; k < 100; k++) next_tick();
    check("terminal_alive",   32'(alive),   32'd0);
    check("terminal_visible", 32'(visible), 32'd0);
`endif

    // en low freezes motion and ticks but still accepts hits.
    do_reset();
    en = 1'b0;
    repeat (20) step();
    check("en0_pos", 32'(enemy_pos), 32'(6'b011_011));
    hit = 2'b10; step(); hit = 2'b00;
    check("en0_kill",  32'(kill_cnt), 32'd1);
    check("en0_alive", 32'(alive),    32'd1);
    en = 1'b1;
    repeat (40) step();

    // Long free run: model and range check on every cycle.
    do_reset();
    repeat (40000) step();

    // Reset in the middle of DYING, saturating the kill count first when lanes can respawn.
    do_reset();
    hit = 2'b11;
`ifdef ENEMY_RESPAWN_EN
    begin
      int b = 0;
      while (kill_cnt != 8'd255 && b < 8000) begin step(); b++; end
      check("kill_reach_255", 32'(kill_cnt), 32'd255);
      repeat (200) step();
      check("kill_saturate", 32'(kill_cnt), 32'd255);
      b = 0;
      while (alive != 2'b00 && b < 100) begin step(); b++; end
    end
`else
    step();
`endif
    hit = 2'b00;
    next_tick();
    check("mid_dying", 32'(alive), 32'd0);
    rst = 1'b0; step(); rst = 1'b1;
    check("rst2_pos",     32'(enemy_pos), 32'(6'b011_011));
    check("rst2_alive",   32'(alive),     32'd3);
    check("rst2_visible", 32'(visible),   32'd3);
    check("rst2_kill",    32'(kill_cnt),  32'd0);
    check("rst2_tick",    32'(tick),      32'd0);
    repeat (4) step();
    check("rst2_seed_move", 32'(enemy_pos), 32'(6'b100_010));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
